// File: rtl/io_bus_responder.sv
// Data-memory bus responder: RAM, GPIO, countdown timer and a read-zero hole behind one bus port.
// Define IO_BUS_ERR_COUNT_EN to add the saturating unmapped-access counter ERRCNT at 0x818.
module io_bus_responder #(
  parameter int RAM_WORDS   = 64,
  parameter int GPIO_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [31:0]       a,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [11:0] ADDR_GPIO_OUT = 12'h800;
  localparam logic [11:0] ADDR_GPIO_IN  = 12'h804;
  localparam logic [11:0] ADDR_CTRL     = 12'h808;
  localparam logic [11:0] ADDR_LOAD     = 12'h80C;
  localparam logic [11:0] ADDR_COUNT    = 12'h810;
  localparam logic [11:0] ADDR_STATUS   = 12'h814;
  localparam logic [11:0] ADDR_ERRCNT   = 12'h818;

  logic [11:0]       reg_addr;
  logic              ram_sel;
  logic [31:0]       ram [RAM_WORDS];
  logic [GPIO_W-1:0] gpio_q;
  logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
  logic              en_q, auto_q, irq_en_q, expired_q;
  logic [31:0]       load_q, count_q, count_next;
  logic              en_next, expire;
  logic              unused_addr;

  assign reg_addr    = {a[11:2], 2'b00};
  assign ram_sel     = a[11:2] < 10'(RAM_WORDS);
  assign unused_addr = ^{a[31:12], a[1:0]};
  assign gpio_out    = gpio_q;
  assign timer_irq   = expired_q & irq_en_q;

  // RAM keeps its contents through reset, but a write during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && we && ram_sel)
      ram[a[AW+1:2]] <= wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    expire     = en_q && (count_q == '0);
    count_next = count_q;
    en_next    = en_q;
    if (en_q) begin
      if (count_q != '0)  count_next = count_q - 32'd1;
      else if (auto_q)    count_next = load_q;
      else                en_next    = 1'b0;
    end
  end

  // Bus writes are applied after the timer step so they override it; expiry beats a STATUS clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q    <= '0;
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      load_q    <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      en_q    <= en_next;
      count_q <= count_next;
      if (we && reg_addr == ADDR_GPIO_OUT) gpio_q <= wd[GPIO_W-1:0];
      if (we && reg_addr == ADDR_CTRL) {irq_en_q, auto_q, en_q} <= wd[2:0];
      if (we && reg_addr == ADDR_LOAD) begin
        load_q  <= wd;
        count_q <= wd;
      end
      if (expire)
        expired_q <= 1'b1;
      else if (we && reg_addr == ADDR_STATUS && wd[0])
        expired_q <= 1'b0;
    end
  end

`ifdef IO_BUS_ERR_COUNT_EN
  logic [15:0] err_q;
  logic        reg_mapped, err_hit;

  always_comb begin
    reg_mapped = ram_sel || (reg_addr inside {ADDR_GPIO_OUT, ADDR_GPIO_IN, ADDR_CTRL,
                                              ADDR_LOAD, ADDR_COUNT, ADDR_STATUS, ADDR_ERRCNT});
    err_hit    = !reg_mapped || (a[1:0] != 2'b00) ||
                 (we && (reg_addr == ADDR_GPIO_IN || reg_addr == ADDR_COUNT));
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= '0;
    else if (we && reg_addr == ADDR_ERRCNT)
      err_q <= '0;
    else if (err_hit && err_q != 16'hFFFF)
      err_q <= err_q + 16'd1;
  end
`endif

  always_comb begin
    rd = '0;
    if (ram_sel) begin
      rd = ram[a[AW+1:2]];
    end else begin
      case (reg_addr)
        ADDR_GPIO_OUT: rd = 32'(gpio_q);
        ADDR_GPIO_IN:  rd = 32'(sync_q[SYNC_STAGES-1]);
        ADDR_CTRL:     rd = {29'd0, irq_en_q, auto_q, en_q};
        ADDR_LOAD:     rd = load_q;
        ADDR_COUNT:    rd = count_q;
        ADDR_STATUS:   rd = {31'd0, expired_q};
`ifdef IO_BUS_ERR_COUNT_EN
        ADDR_ERRCNT:   rd = {16'd0, err_q};
`endif
        default:       rd = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_io_bus_responder.sv
// Scoreboard bench for io_bus_responder: directed plan sequence followed by randomized traffic,
// expectations from a register-level reference model; honours IO_BUS_ERR_COUNT_EN.
module tb_io_bus_responder;
  localparam int RAM_WORDS   = 64;
  localparam int GPIO_W      = 16;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b1;
  logic              rst = 1'b0;
  logic              we  = 1'b0;
  logic [31:0]       a   = '0;
  logic [31:0]       wd  = '0;
  logic [31:0]       rd;
  logic [GPIO_W-1:0] gpio_in = '0;
  logic [GPIO_W-1:0] gpio_out;
  logic              timer_irq;

  io_bus_responder #(.RAM_WORDS(RAM_WORDS), .GPIO_W(GPIO_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .we(we), .a(a), .wd(wd), .rd(rd),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model state, expressed as the programmer-visible registers.
  logic [31:0]       m_ram [int];
  logic [GPIO_W-1:0] m_gpio;
  logic [2:0]        m_ctrl;
  logic [31:0]       m_load, m_count;
  bit                m_exp;
  logic [GPIO_W-1:0] m_pins [$];
  logic [15:0]       m_err;
  bit                m_valid = 0;

  function automatic void model_read(input logic [31:0] addr, output logic [31:0] v, output bit known);
    int off;
    off   = int'({addr[11:2], 2'b00});
    v     = '0;
    known = 1;
    if (off < 4 * RAM_WORDS) begin
      known = m_ram.exists(off / 4);
      if (known) v = m_ram[off / 4];
    end else begin
      case (off)
        'h800: v = 32'(m_gpio);
        'h804: v = 32'(m_pins[SYNC_STAGES-1]);
        'h808: v = {29'd0, m_ctrl};
        'h80C: v = m_load;
        'h810: v = m_count;
        'h814: v = {31'd0, m_exp};
`ifdef IO_BUS_ERR_COUNT_EN
        'h818: v = {16'd0, m_err};
`endif
        default: v = '0;
      endcase
    end
  endfunction

  function automatic void model_step(input bit r, input bit w, input logic [31:0] addr,
                                     input logic [31:0] data, input logic [GPIO_W-1:0] pins);
    int off;
    bit fired, bad;
    off = int'({addr[11:2], 2'b00});
    if (r) begin
      m_gpio = '0; m_ctrl = '0; m_load = '0; m_count = '0; m_exp = 0; m_err = '0;
      m_pins.delete();
      for (int i = 0; i < SYNC_STAGES; i++) m_pins.push_back('0);
      m_valid = 1;
      return;
    end
`ifdef IO_BUS_ERR_COUNT_EN
    bad = !(off < 4 * RAM_WORDS || (off >= 'h800 && off <= 'h818)) || addr[1:0] != 2'b00 ||
          (w && (off == 'h804 || off == 'h810));
    if (w && off == 'h818)             m_err = '0;
    else if (bad && m_err != 16'hFFFF) m_err = m_err + 16'd1;
`else
    bad = 0;
`endif
    fired = 0;
    if (m_ctrl[0]) begin
      if (m_count > 0) m_count = m_count - 1;
      else begin
        fired = 1;
        if (m_ctrl[1]) m_count = m_load;
        else           m_ctrl[0] = 1'b0;
      end
    end
    if (w) begin
      if (off < 4 * RAM_WORDS) m_ram[off / 4] = data;
      else if (off == 'h800)   m_gpio = data[GPIO_W-1:0];
      else if (off == 'h808)   m_ctrl = data[2:0];
      else if (off == 'h80C)   begin m_load = data; m_count = data; end
      else if (off == 'h814 && data[0]) m_exp = 0;
    end
    if (fired) m_exp = 1;
    m_pins.push_front(pins);
    void'(m_pins.pop_back());
  endfunction

  // One bus cycle: drive inputs, queue expectations from pre-edge model state, then advance the model.
  task automatic applyStimulus(input bit r, input bit w, input logic [31:0] addr, input logic [31:0] data,
                               input string name, input bit has_c = 0, input logic [31:0] cval = '0);
    logic [31:0] ev;
    bit          kn;
    rst = r; we = w; a = addr; wd = data;
    if (m_valid) begin
      model_read(addr, ev, kn);
      if (kn) sb.push_back('{name: {name, ".rd"}, kind: 0, exp: ev});
      sb.push_back('{name: {name, ".gpio_out"}, kind: 1, exp: 32'(m_gpio)});
      sb.push_back('{name: {name, ".timer_irq"}, kind: 2, exp: {31'd0, m_exp & m_ctrl[2]}});
    end
    if (has_c) sb.push_back('{name: {name, ".const"}, kind: 0, exp: cval});
    @(posedge clk);
    model_step(r, w, addr, data, gpio_in);
    #1;
  endtask

  task automatic checkOutput(input chk_t c);
    logic [31:0] act;
    case (c.kind)
      0:       act = rd;
      1:       act = 32'(gpio_out);
      default: act = {31'd0, timer_irq};
    endcase
    n_total++;
    if (act !== c.exp)
      $display("[TB] FAIL %s: got %h expected %h at %0t", c.name, act, c.exp, $time);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) checkOutput(sb.pop_front());
  end

  task automatic rdc(input logic [31:0] addr, input logic [31:0] v, input string name);
    applyStimulus(0, 0, addr, '0, name, 1, v);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input string name);
    applyStimulus(0, 1, addr, data, name);
  endtask

  initial begin
    int off;
    logic [31:0] addr, data;
    $display("[TB] start");
    applyStimulus(1, 0, 32'h800, '0, "reset0");
    applyStimulus(1, 0, 32'h800, '0, "reset1");
    rdc(32'h800, 0, "rst_gpio");
    rdc(32'h808, 0, "rst_ctrl");
    rdc(32'h810, 0, "rst_count");
    rdc(32'h814, 0, "rst_status");
    wr(32'h14, 32'hDEADBEEF, "ram_wr");
    rdc(32'h14, 32'hDEADBEEF, "ram_rd");
    rdc(32'h1014, 32'hDEADBEEF, "ram_alias");

    wr(32'h80C, 3, "load3");
    wr(32'h808, 5, "ctrl5");
    rdc(32'h810, 3, "cnt3");
    rdc(32'h810, 2, "cnt2");
    rdc(32'h810, 1, "cnt1");
    rdc(32'h810, 0, "cnt0");
    rdc(32'h814, 1, "expired");
    rdc(32'h808, 4, "en_cleared");
    rdc(32'h810, 0, "cnt_hold");
    wr(32'h814, 1, "status_clr");
    rdc(32'h814, 0, "status_cleared");

    wr(32'h80C, 2, "load2");
    wr(32'h808, 3, "ctrl3");
    rdc(32'h810, 2, "ar2a");
    rdc(32'h810, 1, "ar1a");
    rdc(32'h810, 0, "ar0a");
    rdc(32'h810, 2, "ar2b");
    rdc(32'h810, 1, "ar1b");
    applyStimulus(0, 1, 32'h814, 1, "clr_on_reload", 1, 1);
    rdc(32'h814, 1, "expiry_wins");
    wr(32'h808, 0, "timer_off");

    wr(32'h800, 32'hA5A5, "gpio_wr");
    rdc(32'h800, 32'hA5A5, "gpio_rd");
    gpio_in = 16'h1234;
    for (int k = 0; k <= SYNC_STAGES; k++)
      rdc(32'h804, (k == SYNC_STAGES) ? 32'h1234 : 32'h0, $sformatf("sync%0d", k));

    wr(32'h80C, 7, "load7");
    wr(32'h808, 1, "ctrl_en");
    rdc(32'h810, 7, "cnt7");
    applyStimulus(1, 1, 32'h800, 32'hFFFF, "rst_mid");
    rdc(32'h810, 0, "rst_cnt");
    rdc(32'h808, 0, "rst_ctrl2");
    rdc(32'h800, 0, "rst_gpio2");
    rdc(32'h14, 32'hDEADBEEF, "ram_kept");

`ifdef IO_BUS_ERR_COUNT_EN
    wr(32'h900, 1, "err_unmapped");
    wr(32'h810, 1, "err_ro");
    applyStimulus(0, 0, 32'h802, '0, "err_misaligned");
    rdc(32'h818, 3, "errcnt3");
    wr(32'h818, 0, "errcnt_clr");
    rdc(32'h818, 0, "errcnt0");
`else
    rdc(32'h818, 0, "hole_818");
`endif

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) gpio_in = GPIO_W'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2:       off = $urandom_range(0, RAM_WORDS - 1) * 4;
        3, 4, 5, 6, 7: off = 'h800 + $urandom_range(0, 6) * 4;
        8:             off = $urandom_range(0, 4095) & 'hFFC;
        default:       off = $urandom_range(0, 4095);
      endcase
      addr = {20'($urandom), 12'(off)};
      data = $urandom;
      if ((off & 'hFFC) == 'h80C) data = $urandom_range(0, 6);
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0, addr, data, "rand");
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
